// File: rtl/rr_select_arb.sv
// Round-robin arbiter producing a registered select index and one-hot grant
// for a SIZE-input mux; grants are sticky until acknowledged.
module rr_select_arb #(
    parameter int SIZE = 4,
    parameter int BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] req,
    input  logic            ack,
    output logic            grant_valid,
    output logic [BITS-1:0] grant_sel,
    output logic [SIZE-1:0] grant_onehot
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] sel_q, sel_d;
    logic [SIZE-1:0] oh_q, oh_d;
    logic [BITS-1:0] ptr_q, ptr_d;

    logic [BITS-1:0] ptr_inc;
    logic [BITS-1:0] arb_base;
    logic            win_found;
    logic [BITS-1:0] win_idx;
    logic            accept;

    assign accept = (state_q == GRANT) && ack;

    // Pointer advance wraps at SIZE-1, not at the natural width of the index.
    assign ptr_inc  = (int'(sel_q) == SIZE - 1) ? '0 : sel_q + BITS'(1);
    assign arb_base = accept ? ptr_inc : ptr_q;

    always_comb begin : arb_scan
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < SIZE; i++) begin
            idx = int'(arb_base) + i;
            if (idx >= SIZE) idx = idx - SIZE;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = BITS'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        oh_d    = oh_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    sel_d   = win_idx;
                    oh_d    = SIZE'(1) << win_idx;
                end
            end
            GRANT: begin
                if (ack) begin
                    ptr_d = ptr_inc;
                    if (win_found) begin
                        sel_d = win_idx;
                        oh_d  = SIZE'(1) << win_idx;
                    end else begin
                        state_d = IDLE;
                        oh_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            oh_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            oh_q    <= oh_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_valid  = (state_q == GRANT);
    assign grant_sel    = sel_q;
    assign grant_onehot = oh_q;

endmodule

// File: tb/tb_rr_select_arb.sv
// Directed bench for rr_select_arb (SIZE=4, BITS=2) with hand-computed grants.
module tb_rr_select_arb;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       grant_valid;
    logic [1:0] grant_sel;
    logic [3:0] grant_onehot;

    int n_chk;
    int n_fail;

    rr_select_arb #(.SIZE(4), .BITS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel),
        .grant_onehot(grant_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] oh);
        chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
        chk({tag, ".sel"}, 32'(grant_sel), 32'(s));
        chk({tag, ".onehot"}, 32'(grant_onehot), 32'(oh));
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        req = 4'b1111;
        ack = 1'b0;

        // Reset held two cycles with all requests pending.
        step(); chk_out("rst_c1", 1'b0, 2'd0, 4'b0000);
        step(); chk_out("rst_c2", 1'b0, 2'd0, 4'b0000);
        rst = 1'b0;
        step(); chk_out("first_grant", 1'b1, 2'd0, 4'b0001);

        // Full request, ack every cycle: back-to-back rotation.
        ack = 1'b1;
        step(); chk_out("rot1", 1'b1, 2'd1, 4'b0010);
        step(); chk_out("rot2", 1'b1, 2'd2, 4'b0100);
        step(); chk_out("rot3", 1'b1, 2'd3, 4'b1000);
        req = 4'b1001;
        step(); chk_out("wrap0", 1'b1, 2'd0, 4'b0001);
        step(); chk_out("skip3", 1'b1, 2'd3, 4'b1000);
        step(); chk_out("wrap0b", 1'b1, 2'd0, 4'b0001);

        // Get to grant 1, then drop req without ack: grant is sticky.
        req = 4'b0010;
        step(); chk_out("g1", 1'b1, 2'd1, 4'b0010);
        req = 4'b0000;
        ack = 1'b0;
        step(); chk_out("sticky_a", 1'b1, 2'd1, 4'b0010);
        step(); chk_out("sticky_b", 1'b1, 2'd1, 4'b0010);
        ack = 1'b1;
        step(); chk_out("ack_to_idle", 1'b0, 2'd1, 4'b0000);
        step(); chk_out("ack_in_idle", 1'b0, 2'd1, 4'b0000);
        // ptr should be 2 (from the ack of grant 1), untouched by the idle ack.
        ack = 1'b0;
        req = 4'b1111;
        step(); chk_out("ptr_kept", 1'b1, 2'd2, 4'b0100);

        // Return to IDLE (ptr -> 3), then single request 2 held without ack.
        ack = 1'b1;
        req = 4'b0000;
        step(); chk_out("idle_again", 1'b0, 2'd2, 4'b0000);
        ack = 1'b0;
        req = 4'b0100;
        step(); chk_out("single_c1", 1'b1, 2'd2, 4'b0100);
        req = 4'b1011;
        step(); chk_out("single_c2", 1'b1, 2'd2, 4'b0100);
        step(); chk_out("single_c3", 1'b1, 2'd2, 4'b0100);

        // Reset during grant, overriding ack; arbitration restarts at ptr 0.
        rst = 1'b1;
        ack = 1'b1;
        req = 4'b1111;
        step(); chk_out("rst_in_grant", 1'b0, 2'd0, 4'b0000);
        rst = 1'b0;
        ack = 1'b0;
        step(); chk_out("post_rst", 1'b1, 2'd0, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_select_arb.md
RR_SELECT_ARB -- requirements
Module: rr_select_arb

Interface
REQ-001 Parameter SIZE, default 4: number of requesters; also the number of input slices in the downstream parameterized mux.
REQ-002 Parameter BITS, default 2: width of the select index; SHALL satisfy SIZE <= 2**BITS.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 req  input  SIZE: request vector, bit i = requester i wants the mux output.
REQ-006 ack  input  1: consumer accepts the current grant this cycle.
REQ-007 grant_valid  output  1: registered; grant_sel/grant_onehot are meaningful.
REQ-008 grant_sel  output  BITS: registered index driving the downstream mux select.
REQ-009 grant_onehot  output  SIZE: registered one-hot form of grant_sel; all-zero when grant_valid=0.

Function
REQ-010 Two states: IDLE (grant_valid=0) and GRANT (grant_valid=1); state is encoded by grant_valid.
REQ-011 Internal priority pointer ptr, BITS wide, range 0..SIZE-1; the requester at ptr has highest priority, then ptr+1, and so on circularly.
REQ-012 Arbitration picks the first set bit of req scanning from ptr upward, wrapping from SIZE-1 to 0; combinational, single pass.
REQ-013 IDLE, any req bit set at edge N: GRANT at N+1 with grant_sel = winner, grant_onehot = 1<<winner; latency is 1 cycle.
REQ-014 IDLE, req all-zero: remain IDLE; outputs unchanged (grant_sel holds its last value, grant_onehot = 0).
REQ-015 GRANT without ack: grant_sel, grant_onehot and grant_valid SHALL hold stable regardless of req changes (grants are sticky, including when the granted req bit drops).
REQ-016 GRANT with ack: ptr <= grant_sel+1, wrapping SIZE-1 -> 0 (not 2**BITS-1 -> 0 when SIZE < 2**BITS).
REQ-017 GRANT with ack: the same cycle re-arbitrates using the updated ptr value against current req; if a winner exists, the next cycle is GRANT with the new winner (back-to-back, no bubble); otherwise the next cycle is IDLE.
REQ-018 ack while IDLE SHALL be ignored; ptr is unchanged.
REQ-019 ptr changes only on an accepted grant (GRANT and ack); never on grant issue.
REQ-020 grant_sel SHALL never take a value >= SIZE.
REQ-021 No combinational path from req or ack to any output.

Reset
REQ-022 rst=1 at an edge: grant_valid=0, grant_sel=0, grant_onehot=0, ptr=0, regardless of req/ack.
REQ-023 rst asserted during GRANT drops the grant without updating ptr from it; the first post-reset arbitration starts from ptr=0.
REQ-024 rst overrides ack and req in the same cycle.

Verification (SIZE=4, BITS=2)
REQ-025 rst=1 for 2 cycles with req=4'b1111 -> grant_valid=0, grant_sel=0, grant_onehot=0 on both cycles; first grant after release is sel=0 one cycle later.
REQ-026 IDLE, req=4'b0100, no ack for 3 cycles -> one cycle later grant_valid=1, grant_sel=2, grant_onehot=4'b0100, held stable for all 3 cycles.
REQ-027 req=4'b1111 held, ack=1 every cycle while valid -> grant_sel sequence 0,1,2,3,0 with grant_valid continuously 1.
REQ-028 After grant 3 is acked (ptr wraps to 0), req=4'b1001 with ack each cycle -> grant_sel 0 then 3, then 0.
REQ-029 Grant sel=1 active, req drops to 0 with no ack -> grant holds sel=1; ack with req=0 -> grant_valid=0 and grant_onehot=0 next cycle; ack asserted while IDLE -> no state change.
REQ-030 rst pulsed during GRANT with sel=2 -> next cycle all outputs 0; with req=4'b1111 afterwards, first grant_sel=0.
